// File: rtl/bgd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bgd_pkg
//  Description : Shared constants and types for the BGD datapath (multiplier,
//                dot-product accumulator and sigmoid stages).
//  Revision    : 1.0  initial release
// ============================================================================
package bgd_pkg;

    // Datapath widths shared by every BGD stage
    localparam int c_bgd_data_w = 16;
    localparam int c_bgd_acc_w  = 40;
    localparam int c_bgd_cnt_w  = 8;
    localparam int c_bgd_lanes  = 4;

    // Signed saturation limits of a c_bgd_data_w result
    localparam logic signed [c_bgd_data_w-1:0] c_bgd_sat_max =
        {1'b0, {(c_bgd_data_w-1){1'b1}}};
    localparam logic signed [c_bgd_data_w-1:0] c_bgd_sat_min =
        {1'b1, {(c_bgd_data_w-1){1'b0}}};

    // Control flags travelling alongside a beat through the pipeline
    typedef struct packed {
        logic valid;
        logic last;
    } bgd_beat_flags_t;

endpackage : bgd_pkg
`default_nettype wire

// File: rtl/bgd_lane_sum.sv
`default_nettype none
// ============================================================================
//  Module      : bgd_lane_sum
//  Description : Combinational adder tree summing LANES signed products,
//                each sign-extended to the accumulator width.
//  Revision    : 1.0  initial release
// ============================================================================
module bgd_lane_sum #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic [LANES*DATA_W-1:0] i_data,
    output logic signed [ACC_W-1:0] o_sum
);

    logic signed [ACC_W-1:0] w_ext [LANES];

    // Sign-extend every lane to the accumulator width
    for (genvar k = 0; k < LANES; k++) begin : g_ext
        assign w_ext[k] = {{(ACC_W-DATA_W){i_data[k*DATA_W+DATA_W-1]}},
                           i_data[k*DATA_W +: DATA_W]};
    end

    // Sum all extended lanes; headroom in ACC_W keeps this exact
    always_comb begin
        o_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            o_sum = o_sum + w_ext[k];
        end
    end

endmodule : bgd_lane_sum
`default_nettype wire

// File: rtl/bgd_dot_accum.sv
`default_nettype none
// ============================================================================
//  Module      : bgd_dot_accum
//  Description : Two-stage dot-product accumulator. Stage 1 registers the lane
//                sum of each beat, stage 2 accumulates beats of a vector and
//                emits a saturated result with its beat count on the last beat.
//                The whole pipeline stalls while a result is held unaccepted.
//  Revision    : 1.0  initial release
// ============================================================================
module bgd_dot_accum
    import bgd_pkg::*;
#(
    parameter int LANES  = c_bgd_lanes,
    parameter int DATA_W = c_bgd_data_w,
    parameter int ACC_W  = c_bgd_acc_w,
    parameter int CNT_W  = c_bgd_cnt_w
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_last,
    output logic                    mul_ce,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        out_count
);

    // Clamp limits at accumulator width; equal c_bgd_sat_max/min at the default width
    localparam logic signed [ACC_W-1:0] c_sat_max =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        c_cnt_max = '1;

    logic                    w_ce;
    logic signed [ACC_W-1:0] w_lane_sum;
    logic                    w_start;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic signed [ACC_W-1:0] w_clamped;
    logic                    w_clamp_hit;

    logic signed [ACC_W-1:0] s1_sum_q,     s1_sum_d;
    bgd_beat_flags_t         s1_flags_q,   s1_flags_d;
    logic signed [ACC_W-1:0] acc_q,        acc_d;
    logic [CNT_W-1:0]        cnt_q,        cnt_d;
    logic                    acc_last_q,   acc_last_d;
    logic                    acc_busy_q,   acc_busy_d;
    logic                    out_valid_q,  out_valid_d;
    logic [DATA_W-1:0]       out_data_q,   out_data_d;
    logic                    out_sat_q,    out_sat_d;
    logic [CNT_W-1:0]        out_count_q,  out_count_d;

    bgd_lane_sum #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_lane_sum (
        .i_data (in_data),
        .o_sum  (w_lane_sum)
    );

    // Whole pipeline advances unless a held result is blocking the output
    assign w_ce      = !(out_valid_q && !out_ready);
    assign in_ready  = w_ce;
    assign mul_ce    = w_ce;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_count = out_count_q;

    // Next accumulator/count for the beat in stage 1, and its clamped value
    always_comb begin
        w_start     = acc_last_q || !acc_busy_q;
        w_acc_next  = w_start ? s1_sum_q : acc_q + s1_sum_q;
        if (w_start) begin
            w_cnt_next = CNT_W'(1);
        end else if (cnt_q == c_cnt_max) begin
            w_cnt_next = cnt_q;
        end else begin
            w_cnt_next = cnt_q + CNT_W'(1);
        end
        w_clamped   = w_acc_next;
        w_clamp_hit = 1'b0;
        if (w_acc_next > c_sat_max) begin
            w_clamped   = c_sat_max;
            w_clamp_hit = 1'b1;
        end else if (w_acc_next < c_sat_min) begin
            w_clamped   = c_sat_min;
            w_clamp_hit = 1'b1;
        end
    end

    // Pipeline next-state: everything holds while ce is low
    always_comb begin
        s1_sum_d    = s1_sum_q;
        s1_flags_d  = s1_flags_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_last_d  = acc_last_q;
        acc_busy_d  = acc_busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;
        if (w_ce) begin
            if (in_valid) begin
                s1_sum_d = w_lane_sum;
            end
            s1_flags_d.valid = in_valid;
            s1_flags_d.last  = in_valid && in_last;
            if (s1_flags_q.valid) begin
                acc_d      = w_acc_next;
                cnt_d      = w_cnt_next;
                acc_last_d = s1_flags_q.last;
                acc_busy_d = 1'b1;
            end
            out_valid_d = s1_flags_q.valid && s1_flags_q.last;
            if (s1_flags_q.valid && s1_flags_q.last) begin
                out_data_d  = w_clamped[DATA_W-1:0];
                out_sat_d   = w_clamp_hit;
                out_count_d = w_cnt_next;
            end
        end
    end

    // State registers; reset overrides the pipeline enable
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_sum_q    <= '0;
            s1_flags_q  <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_last_q  <= 1'b0;
            acc_busy_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            s1_sum_q    <= s1_sum_d;
            s1_flags_q  <= s1_flags_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_last_q  <= acc_last_d;
            acc_busy_q  <= acc_busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

endmodule : bgd_dot_accum
`default_nettype wire
